// File: rtl/pool1_max_stream_pkg.sv
`default_nettype none
// ============================================================================
// pool1_max_stream_pkg : shared FSM encoding and map-geometry helpers
// Revision: 1.0
// ============================================================================
package pool1_max_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int ofm_side(input int ifm_size);
        return ifm_size / 2;
    endfunction

    // Widths never collapse to zero so single-map / tiny-map builds still elaborate.
    function automatic int index_bits(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic int ofm_addr_bits(input int ifm_size);
        return index_bits(ofm_side(ifm_size) * ofm_side(ifm_size));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool1_max_stream_max2_unsigned.sv
`default_nettype none
// ============================================================================
// max2_unsigned : combinational unsigned max, ties resolve to in1
// Revision: 1.0
// ============================================================================
module max2_unsigned #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic [DATA_WIDTH-1:0] max_out
);

    assign max_out = (in2 > in1) ? in2 : in1;

endmodule
`default_nettype wire

// File: rtl/pool1_max_stream.sv
`default_nettype none
// ============================================================================
// pool1_max_stream : streaming 2x2 stride-2 max-pool with one pooled-row line buffer
// Revision: 1.0
// ============================================================================
module pool1_max_stream
    import pool1_max_stream_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int IFM_SIZE          = 28,
    parameter int NUMBER_OF_FILTERS = 15,
    parameter int OFM_SIZE          = ofm_side(IFM_SIZE),
    parameter int ADDRESS_SIZE_OFM  = ofm_addr_bits(IFM_SIZE),
    parameter int FILTER_BITS       = index_bits(NUMBER_OF_FILTERS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        data_in_valid,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        data_out_valid,
    output logic [ADDRESS_SIZE_OFM-1:0] ofm_address,
    output logic [FILTER_BITS-1:0]      ofm_index,
    output logic                        busy,
    output logic                        done
);

    localparam int                     CNT_BITS  = index_bits(IFM_SIZE);
    localparam logic [CNT_BITS-1:0]    LAST_POS  = CNT_BITS'(IFM_SIZE - 1);
    localparam logic [FILTER_BITS-1:0] LAST_FILT = FILTER_BITS'(NUMBER_OF_FILTERS - 1);

    generate
        if ((IFM_SIZE % 2) != 0) begin : g_odd_ifm
            $fatal(1, "pool1_max_stream: IFM_SIZE must be even");
        end
    endgenerate

    state_t                  state;
    state_t                  state_next;
    logic [CNT_BITS-1:0]     col;
    logic [CNT_BITS-1:0]     row;
    logic [FILTER_BITS-1:0]  filt;
    logic [DATA_WIDTH-1:0]   hold_r;
    logic [DATA_WIDTH-1:0]   linebuf [OFM_SIZE];

    logic                        accept;
    logic                        col_wrap;
    logic                        row_wrap;
    logic                        last_in;
    logic [CNT_BITS-1:0]         col_half;
    logic [CNT_BITS-1:0]         row_half;
    logic [DATA_WIDTH-1:0]       line_rd;
    logic [DATA_WIDTH-1:0]       pair;
    logic [DATA_WIDTH-1:0]       merged;
    logic [ADDRESS_SIZE_OFM-1:0] out_addr;

    assign accept   = (state == ST_RUN) && data_in_valid;
    assign col_wrap = (col == LAST_POS);
    assign row_wrap = (row == LAST_POS);
    assign last_in  = accept && col_wrap && row_wrap && (filt == LAST_FILT);
    assign col_half = col >> 1;
    assign row_half = row >> 1;
    assign line_rd  = linebuf[col_half];
    assign out_addr = ADDRESS_SIZE_OFM'(row_half) * ADDRESS_SIZE_OFM'(OFM_SIZE)
                    + ADDRESS_SIZE_OFM'(col_half);

    // Earlier pixel goes on in1 so ties keep the earlier value.
    max2_unsigned #(.DATA_WIDTH(DATA_WIDTH)) u_pair (
        .in1     (hold_r),
        .in2     (data_in),
        .max_out (pair)
    );

    max2_unsigned #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
        .in1     (line_rd),
        .in2     (pair),
        .max_out (merged)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)   state_next = ST_RUN;
            ST_RUN:  if (last_in) state_next = ST_DONE;
            ST_DONE:              state_next = ST_IDLE;
            default:              state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col  <= '0;
            row  <= '0;
            filt <= '0;
        end else if ((state == ST_IDLE) && start) begin
            col  <= '0;
            row  <= '0;
            filt <= '0;
        end else if (accept) begin
            col <= col_wrap ? '0 : col + 1'b1;
            if (col_wrap) row <= row_wrap ? '0 : row + 1'b1;
            if (col_wrap && row_wrap) filt <= (filt == LAST_FILT) ? '0 : filt + 1'b1;
        end
    end

    // linebuf is not cleared between maps: each even row rewrites every entry first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_r <= '0;
            for (int i = 0; i < OFM_SIZE; i++) linebuf[i] <= '0;
        end else if (accept) begin
            if (!col[0])             hold_r            <= data_in;
            else if (!row[0])        linebuf[col_half] <= pair;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            ofm_address    <= '0;
            ofm_index      <= '0;
        end else begin
            data_out_valid <= accept && col[0] && row[0];
            if (accept && col[0] && row[0]) begin
                data_out    <= merged;
                ofm_address <= out_addr;
                ofm_index   <= filt;
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule
`default_nettype wire
